// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit sitting between the execute stage and a simple req/gnt
// memory bus. One op is in flight at a time: it is accepted in IDLE,
// issued on the bus in REQ, waits for read data in WAIT (loads only) and
// writes the aligned, extended result back with a one-cycle wb_valid pulse.
//
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word ops go to ERR, pulse misalign_err and
//               never touch the bus.
//   undefined : misalign_err is tied 0 and misaligned ops proceed with the
//               byte offset forced (half uses addr[1] only, word uses 0).
//
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   op_valid / op_ready  : op handshake from execute (ready only in IDLE)
//   mem_op_en[4:0]       : {store, word, half, byte, signed}
//   addr, store_data     : effective byte address, store register value
//   rd_idx               : load destination register
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : bus request side
//   bus_gnt, bus_rvalid, bus_rdata           : bus response side
//   wb_valid, wb_rd, wb_data                 : load writeback (1-cycle pulse)
//   misalign_err                             : misaligned-op trap pulse
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        mem_op_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_idx,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        w_accept;
    logic        w_isWord;
    logic        w_isHalf;
    logic [1:0]  w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    logic        r_isWord;
    logic        r_isHalf;
    logic        r_signed;
    logic [1:0]  r_offset;
    logic [4:0]  r_rd;

    logic [31:0] w_shifted;
    logic [31:0] w_loadData;

`ifdef MEM_MISALIGN_TRAP_EN
    logic        w_misaligned;
`endif

    assign w_accept = op_valid & op_ready;

    // Size decode: word wins over half wins over byte, and an op with no
    // size bit at all is treated as a word.
    assign w_isWord = mem_op_en[3] | ~(mem_op_en[2] | mem_op_en[1]);
    assign w_isHalf = ~mem_op_en[3] & mem_op_en[2];

`ifdef MEM_MISALIGN_TRAP_EN
    // A half on an odd address or a word off a 4-byte boundary cannot be
    // expressed as a single lane mask, so it is trapped.
    assign w_misaligned = (w_isHalf & addr[0]) |
                          (w_isWord & (addr[1:0] != 2'b00));
`endif

    // Byte offset within the word, with misaligned half/word forced onto
    // their natural boundary. In trap builds misaligned ops never reach the
    // bus, so the forcing is harmless there too.
    always_comb begin
        w_offset = addr[1:0];
        if (w_isWord) begin
            w_offset = 2'b00;
        end else if (w_isHalf) begin
            w_offset = {addr[1], 1'b0};
        end
    end

    // Lane enables and store data replication for the incoming op; both are
    // captured at accept so the bus side stays stable while waiting for gnt.
    always_comb begin
        w_be    = 4'b0001 << w_offset;
        w_wdata = {4{store_data[7:0]}};
        if (w_isWord) begin
            w_be    = 4'b1111;
            w_wdata = store_data;
        end else if (w_isHalf) begin
            w_be    = w_offset[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{store_data[15:0]}};
        end
    end

    // Load result: bring the addressed lane down to bit 0, then keep the
    // byte/half/word and sign- or zero-extend it.
    assign w_shifted = bus_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_loadData = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
        if (r_isWord) begin
            w_loadData = w_shifted;
        end else if (r_isHalf) begin
            w_loadData = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. bus_we doubles as the registered store flag; grant
    // and read-valid are only looked at in the state that expects them.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    w_nextState = w_misaligned ? S_ERR : S_REQ;
`else
                    w_nextState = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    w_nextState = bus_we ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    w_nextState = S_IDLE;
                end
            end
            S_ERR: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        op_ready = (r_state == S_IDLE);
        bus_req  = (r_state == S_REQ);
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_err = (r_state == S_ERR);
`else
        misalign_err = 1'b0;
`endif
    end

    // Op capture and writeback registers. wb_valid is a single-cycle pulse
    // raised on the edge where read data arrives in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            r_isWord  <= 1'b0;
            r_isHalf  <= 1'b0;
            r_signed  <= 1'b0;
            r_offset  <= 2'b00;
            r_rd      <= 5'd0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'h0;
        end else begin
            wb_valid <= 1'b0;
            if (w_accept) begin
                bus_we    <= mem_op_en[4];
                bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                bus_be    <= w_be;
                bus_wdata <= w_wdata;
                r_isWord  <= w_isWord;
                r_isHalf  <= w_isHalf;
                r_signed  <= mem_op_en[0];
                r_offset  <= w_offset;
                r_rd      <= rd_idx;
            end
            if ((r_state == S_WAIT) && bus_rvalid) begin
                wb_valid <= 1'b1;
                wb_rd    <= r_rd;
                wb_data  <= w_loadData;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A behavioural model computes the
// expected bus request and load result of each op from its size in bytes and
// plain arithmetic on the address; directed ops cover the named scenarios
// and a randomized loop covers the rest. Expectations for misaligned ops
// follow MEM_MISALIGN_TRAP_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  mem_op_en;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_idx;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    int testCount = 0;
    int failCount = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .mem_op_en    (mem_op_en),
        .addr         (addr),
        .store_data   (store_data),
        .rd_idx       (rd_idx),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single point of comparison for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int modelSize(input logic [4:0] opEn);
        if (opEn[3])      return 4;
        else if (opEn[2]) return 2;
        else if (opEn[1]) return 1;
        else              return 4;
    endfunction

    function automatic bit modelMisaligned(input logic [4:0] opEn, input logic [31:0] a);
        int sz = modelSize(opEn);
        return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
    endfunction

    // Byte offset actually used: natural boundary of the access size.
    function automatic int modelOffset(input logic [4:0] opEn, input logic [31:0] a);
        int sz = modelSize(opEn);
        return ((a % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] modelBe(input logic [4:0] opEn, input logic [31:0] a);
        int sz = modelSize(opEn);
        int lanes = (1 << sz) - 1;
        return 4'(lanes << modelOffset(opEn, a));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [4:0] opEn, input logic [31:0] sd);
        int sz = modelSize(opEn);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = sd[8*(i % sz) +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [4:0] opEn, input logic [31:0] a,
                                              input logic [31:0] rdata);
        int sz = modelSize(opEn);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*sz)) - 32'h1;
        logic [31:0] v = (rdata >> (8 * modelOffset(opEn, a))) & mask;
        if (opEn[0] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Runs one complete op through the unit and checks every cycle of it.
    // gntDelay: cycles bus_req is held before bus_gnt is given.
    // rvDelay : cycles in WAIT before bus_rvalid is given.
    task automatic applyStimulus(input logic [4:0] opEn, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [4:0] rd,
                                 input int gntDelay, input int rvDelay,
                                 input logic [31:0] rdata, input string name);
        bit trap = 1'b0;
        int reqCycles = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = modelMisaligned(opEn, a);
`endif
        checkOutput({name, "_ready_idle"}, 32'(op_ready), 32'd1);
        op_valid   = 1'b1;
        mem_op_en  = opEn;
        addr       = a;
        store_data = sd;
        rd_idx     = rd;
        tick();
        // Scramble the op inputs so any failure to register them shows up.
        op_valid   = 1'b0;
        mem_op_en  = 5'($urandom);
        addr       = $urandom;
        store_data = $urandom;
        rd_idx     = 5'($urandom);
        checkOutput({name, "_ready_busy"}, 32'(op_ready), 32'd0);

        if (trap) begin
            checkOutput({name, "_misalign_pulse"}, 32'(misalign_err), 32'd1);
            checkOutput({name, "_no_req_err"}, 32'(bus_req), 32'd0);
            tick();
            checkOutput({name, "_misalign_end"}, 32'(misalign_err), 32'd0);
            checkOutput({name, "_no_req_after"}, 32'(bus_req), 32'd0);
            checkOutput({name, "_no_wb"}, 32'(wb_valid), 32'd0);
            checkOutput({name, "_ready_after_err"}, 32'(op_ready), 32'd1);
            return;
        end

        for (int k = 0; k <= gntDelay; k++) begin
            checkOutput({name, "_req"}, 32'(bus_req), 32'd1);
            checkOutput({name, "_we"}, 32'(bus_we), 32'(opEn[4]));
            checkOutput({name, "_addr"}, bus_addr, a & ~32'h3);
            checkOutput({name, "_be"}, 32'(bus_be), 32'(modelBe(opEn, a)));
            checkOutput({name, "_wdata"}, bus_wdata, modelWdata(opEn, sd));
            checkOutput({name, "_no_misalign"}, 32'(misalign_err), 32'd0);
            reqCycles++;
            bus_gnt    = (k == gntDelay);
            bus_rvalid = 1'($urandom);   // must be ignored outside WAIT
            bus_rdata  = $urandom;
            tick();
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        checkOutput({name, "_req_cycles"}, 32'(reqCycles), 32'(gntDelay + 1));
        checkOutput({name, "_req_drop"}, 32'(bus_req), 32'd0);
        checkOutput({name, "_no_wb_early"}, 32'(wb_valid), 32'd0);

        if (opEn[4]) begin
            checkOutput({name, "_store_done"}, 32'(op_ready), 32'd1);
            return;
        end

        for (int k = 0; k < rvDelay; k++) begin
            bus_gnt = 1'($urandom);      // must be ignored outside REQ
            tick();
            checkOutput({name, "_wait_busy"}, 32'(op_ready), 32'd0);
            checkOutput({name, "_wait_no_wb"}, 32'(wb_valid), 32'd0);
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = $urandom;
        checkOutput({name, "_wb_valid"}, 32'(wb_valid), 32'd1);
        checkOutput({name, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        checkOutput({name, "_wb_data"}, wb_data, modelLoad(opEn, a, rdata));
        checkOutput({name, "_ready_wb"}, 32'(op_ready), 32'd1);
        tick();
        checkOutput({name, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    // Main sequence: reset, directed scenarios, reset in WAIT, random ops.
    initial begin
        rst_n      = 1'b0;
        op_valid   = 1'b1;
        mem_op_en  = 5'b01000;
        addr       = 32'h0000_0104;
        store_data = 32'h1234_5678;
        rd_idx     = 5'd7;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        tick();
        tick();
        checkOutput("rst_ready", 32'(op_ready), 32'd1);
        checkOutput("rst_req", 32'(bus_req), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_be", 32'(bus_be), 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        op_valid   = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        rst_n      = 1'b1;
        tick();

        // LW 0x100, zero-wait grant and data: wb_valid three cycles after accept.
        applyStimulus(5'b01000, 32'h0000_0100, 32'h0, 5'd3, 0, 0, 32'hDEAD_BEEF, "lw");
        // LB / LBU at 0x103.
        applyStimulus(5'b00011, 32'h0000_0103, 32'h0, 5'd4, 0, 0, 32'h8012_3456, "lb");
        applyStimulus(5'b00010, 32'h0000_0103, 32'h0, 5'd5, 0, 0, 32'h8012_3456, "lbu");
        // SH at 0x202 with bus_req held three cycles before grant.
        applyStimulus(5'b10100, 32'h0000_0202, 32'h0000_ABCD, 5'd6, 2, 0, 32'h0, "sh");
        checkOutput("sh_be_const", 32'(modelBe(5'b10100, 32'h202)), 32'b1100);
        // Misaligned LW at 0x101.
        applyStimulus(5'b01000, 32'h0000_0101, 32'h0, 5'd8, 1, 2, 32'hCAFE_F00D, "lw_mis");
        // No size bits: treated as a signed word.
        applyStimulus(5'b00001, 32'h0000_0310, 32'h0, 5'd9, 0, 1, 32'h8765_4321, "nosize");
        // LH signed upper half, and SB to lane 1.
        applyStimulus(5'b00101, 32'h0000_0412, 32'h0, 5'd10, 1, 0, 32'h9ABC_1234, "lh");
        applyStimulus(5'b10010, 32'h0000_0501, 32'h0000_00A5, 5'd0, 0, 0, 32'h0, "sb");

        // Reset while waiting for read data: op is dropped, late rvalid ignored.
        op_valid  = 1'b1;
        mem_op_en = 5'b01000;
        addr      = 32'h0000_0600;
        rd_idx    = 5'd11;
        tick();
        op_valid  = 1'b0;
        bus_gnt   = 1'b1;
        tick();
        bus_gnt   = 1'b0;
        checkOutput("rstw_in_wait", 32'(op_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rstw_ready", 32'(op_ready), 32'd1);
        checkOutput("rstw_req", 32'(bus_req), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1111_2222;
        tick();
        bus_rvalid = 1'b0;
        checkOutput("rstw_no_wb", 32'(wb_valid), 32'd0);
        checkOutput("rstw_ready_after", 32'(op_ready), 32'd1);
        tick();
        checkOutput("rstw_no_wb_late", 32'(wb_valid), 32'd0);

        // Randomized ops with a stray grant / read-valid in IDLE between them.
        for (int n = 0; n < 80; n++) begin
            logic [4:0]  opEn;
            logic [31:0] a;
            opEn = 5'($urandom);
            a    = $urandom;
            bus_gnt    = 1'($urandom);
            bus_rvalid = 1'($urandom);
            tick();
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            checkOutput("idle_no_req", 32'(bus_req), 32'd0);
            checkOutput("idle_no_wb", 32'(wb_valid), 32'd0);
            applyStimulus(opEn, a, $urandom, 5'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          $urandom, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, byte-address width; the data width SHALL be fixed at 32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port op_valid, input, 1, a memory op is presented by execute.
REQ-005 The block SHALL have port op_ready, output, 1, the unit accepts an op; the op transfers when op_valid & op_ready.
REQ-006 The block SHALL have port mem_op_en, input, 5, the decoded op {store, word, half, byte, signed} with bit 4 = store and bit 0 = signed.
REQ-007 The block SHALL have ports addr (input, ADDR_W, effective byte address), store_data (input, 32, register value for stores) and rd_idx (input, 5, load destination).
REQ-008 The block SHALL have ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, ADDR_W, word-aligned with [1:0]=0), bus_be (output, 4, byte lanes) and bus_wdata (output, 32).
REQ-009 The block SHALL have ports bus_gnt (input, 1, request accepted), bus_rvalid (input, 1, read data valid) and bus_rdata (input, 32).
REQ-010 The block SHALL have ports wb_valid (output, 1, one-cycle pulse), wb_rd (output, 5), wb_data (output, 32) and misalign_err (output, 1, one-cycle pulse).

Function
REQ-011 The block SHALL implement a state machine with states IDLE, REQ, WAIT and ERR, and SHALL drive op_ready high only in IDLE.
REQ-012 The block SHALL decode size with priority word > half > byte, and SHALL treat a mem_op_en with none of the three size bits set as word.
REQ-013 On accept, the block SHALL register the op, address, store data and rd_idx, and SHALL enter REQ with bus_req high from the next cycle.
REQ-014 In REQ, the block SHALL hold bus_req and all bus_* outputs stable until bus_gnt is sampled high.
REQ-015 A store SHALL move from REQ to IDLE on bus_gnt; a load SHALL move from REQ to WAIT on bus_gnt; bus_req SHALL drop in the cycle after the grant.
REQ-016 bus_be SHALL be 1111 for word, 0011 or 1100 for half (selected by addr[1]), and 1 << addr[1:0] for byte; bus_we SHALL equal the store bit.
REQ-017 bus_wdata SHALL be store_data for word, the low halfword replicated twice for half, and the low byte replicated four times for byte.
REQ-018 In WAIT, on bus_rvalid the block SHALL shift bus_rdata right by 8*addr[1:0], extract the byte, half or word, sign-extend if the signed bit is set (zero-extend otherwise), and pulse wb_valid with wb_rd/wb_data in the next cycle while returning to IDLE.
REQ-019 The block SHALL ignore bus_rvalid outside WAIT, and SHALL ignore bus_gnt outside REQ.
REQ-020 Load latency SHALL be accept (cycle 0) -> bus_req (cycle 1) -> wb_valid one cycle after rvalid; with zero-wait grant and rvalid in cycle 2, wb_valid SHALL occur in cycle 3.
REQ-021 An access SHALL be misaligned when it is a half with addr[0]=1, or a word with addr[1:0]!=0.

Reset
REQ-022 When rst_n is low at a clock edge, state SHALL become IDLE and bus_req, wb_valid and misalign_err SHALL be 0, op_ready SHALL be 1, and bus_addr, bus_be, bus_wdata, wb_rd and wb_data SHALL be 0.
REQ-023 A reset mid-operation (REQ or WAIT) SHALL abandon the op with no wb_valid, and a later bus_rvalid SHALL be ignored.

Configuration
REQ-024 With macro MEM_MISALIGN_TRAP_EN defined, a misaligned op SHALL go IDLE -> ERR, pulse misalign_err for one cycle, issue no bus_req, produce no wb_valid, and return to IDLE.
REQ-025 Without MEM_MISALIGN_TRAP_EN, misalign_err SHALL be tied 0 and misaligned ops SHALL proceed with offset forced: half uses addr[1] only, word uses offset 0.

Verification
REQ-026 The bench SHALL cover: LW at addr 0x100, gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF -> wb_valid in cycle 3, wb_data 0xDEADBEEF.
REQ-027 The bench SHALL cover: LB signed at addr 0x103 with rdata 0x80123456 -> wb_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-028 The bench SHALL cover: SH at addr 0x202 with store_data 0x0000ABCD, gnt delayed 3 cycles -> bus_req held 3 cycles with be=1100, wdata=0xABCDABCD, addr=0x200.
REQ-029 The bench SHALL cover: LW at addr 0x101 -> with the macro, misalign_err pulses and bus_req never rises; without it, bus_addr=0x100, be=1111.
REQ-030 The bench SHALL cover: rst_n low during WAIT, then rvalid -> no wb_valid, and op_ready=1 after reset.
